// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: sequencer states and port identifiers.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DATA  = 2'd2
   } arb_state_e;

   localparam logic OWNER_P0 = 1'b0;
   localparam logic OWNER_P1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick: on a tie the port that did not win last time wins.
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic winner,
   output logic any
);

   always_comb begin
      any = req0 | req1;
      if (req0 && req1) begin
         winner = (last_owner == OWNER_P0) ? OWNER_P1 : OWNER_P0;
      end else begin
         winner = req1 ? OWNER_P1 : OWNER_P0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter and ISSUE/DATA sequencer in front of a synchronous-read memory.
// Requests are only sampled in IDLE; the winning request is latched straight into the memory-side registers.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int N = 32,
   parameter int A = 32
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic [A-1:0] adr0,
   input  logic [A-1:0] adr1,
   input  logic [N-1:0] wd0,
   input  logic [N-1:0] wd1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         rvalid0,
   output logic         rvalid1,
   output logic [N-1:0] rd0,
   output logic [N-1:0] rd1,
   output logic [A-1:0] mem_adr,
   output logic         mem_we,
   output logic [N-1:0] mem_wd,
   input  logic [N-1:0] mem_rd
);

   arb_state_e   state_q, state_d;
   logic         owner_q, owner_d;
   logic         we_q, we_d;
   logic         last_owner_q, last_owner_d;
   logic [A-1:0] mem_adr_q, mem_adr_d;
   logic [N-1:0] mem_wd_q, mem_wd_d;
   logic         mem_we_q, mem_we_d;
   logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic         rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [N-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic         pick_winner, pick_any;

   rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_owner_q),
      .winner     (pick_winner),
      .any        (pick_any)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      last_owner_d = last_owner_q;
      mem_adr_d    = mem_adr_q;
      mem_wd_d     = mem_wd_q;
      mem_we_d     = 1'b0;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      rd0_d        = rd0_q;
      rd1_d        = rd1_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               owner_d      = pick_winner;
               last_owner_d = pick_winner;
               state_d      = ST_ISSUE;
               // Grant and write strobe are registered so they land in the ISSUE cycle.
               if (pick_winner == OWNER_P1) begin
                  we_d      = we1;
                  mem_adr_d = adr1;
                  mem_wd_d  = wd1;
                  mem_we_d  = we1;
                  gnt1_d    = 1'b1;
               end else begin
                  we_d      = we0;
                  mem_adr_d = adr0;
                  mem_wd_d  = wd0;
                  mem_we_d  = we0;
                  gnt0_d    = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            state_d = we_q ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            state_d = ST_IDLE;
            if (owner_q == OWNER_P1) begin
               rd1_d     = mem_rd;
               rvalid1_d = 1'b1;
            end else begin
               rd0_d     = mem_rd;
               rvalid0_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWNER_P0;
         we_q         <= 1'b0;
         last_owner_q <= OWNER_P1;
         mem_adr_q    <= '0;
         mem_wd_q     <= '0;
         mem_we_q     <= 1'b0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rd0_q        <= '0;
         rd1_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         last_owner_q <= last_owner_d;
         mem_adr_q    <= mem_adr_d;
         mem_wd_q     <= mem_wd_d;
         mem_we_q     <= mem_we_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rd0_q        <= rd0_d;
         rd1_q        <= rd1_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rd0     = rd0_q;
   assign rd1     = rd1_q;
   assign mem_adr = mem_adr_q;
   assign mem_we  = mem_we_q;
   assign mem_wd  = mem_wd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: attached synchronous-read memory plus a transaction-level model
// (round-robin order, fixed latencies, memory contents) checked with immediate assertions.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rstb;
   logic        req0, req1, we0, we1;
   logic [31:0] adr0, adr1, wd0, wd1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rd0, rd1, mem_adr, mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   logic [31:0] phys_mem [0:63];
   logic [31:0] ref_mem  [0:63];
   logic [31:0] exp_rd   [2];
   int          m_last_owner;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   mem_port_arbiter #(.N(32), .A(32)) dut (
      .clk(clk), .rstb(rstb),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rd0(rd0), .rd1(rd1),
      .mem_adr(mem_adr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_we) phys_mem[mem_adr[7:2]] <= mem_wd;
      mem_rd <= phys_mem[mem_adr[7:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
      check({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
      check({tag, "_rvalid0"}, {31'd0, rvalid0}, 32'd0);
      check({tag, "_rvalid1"}, {31'd0, rvalid1}, 32'd0);
      check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_rd0"}, rd0, 32'd0);
      check({tag, "_rd1"}, rd1, 32'd0);
      check({tag, "_mem_adr"}, mem_adr, 32'd0);
      check({tag, "_mem_wd"}, mem_wd, 32'd0);
   endtask

   // One or two transactions; port 1 may start off1 cycles after port 0 (0..2, only when port 0 requests).
   task automatic run_pair(input string tag,
                           input bit d0, input bit w0, input logic [31:0] a0, input logic [31:0] v0,
                           input bit d1, input bit w1, input logic [31:0] a1, input logic [31:0] v1,
                           input int off1);
      bit          dd[2], ww[2];
      logic [31:0] aa[2], vv[2], exp_data[2], got_data[2];
      int          exp_g[2], tg[2], tv[2], ng[2], nv[2];
      int          first, second, p, rel, nwe, exp_nwe, excl_bad, we_bad;
      dd[0] = d0; ww[0] = w0; aa[0] = a0; vv[0] = v0;
      dd[1] = d1; ww[1] = w1; aa[1] = a1; vv[1] = v1;
      exp_nwe = 0;
      if (d0 && d1 && off1 == 0) first = (m_last_owner == 0) ? 1 : 0;
      else if (d0) first = 0;
      else first = 1;
      second = 1 - first;
      exp_g[first]  = 0;
      exp_g[second] = ww[first] ? 2 : 3;
      foreach (exp_data[k]) exp_data[k] = 32'd0;
      for (int s = 0; s < 2; s++) begin
         int k;
         k = (s == 0) ? first : second;
         if (dd[k]) begin
            if (ww[k]) begin
               ref_mem[aa[k][7:2]] = vv[k];
               exp_nwe++;
            end else begin
               exp_data[k] = ref_mem[aa[k][7:2]];
               exp_rd[k] = exp_data[k];
            end
            m_last_owner = k;
         end
      end

      @(negedge clk);
      p = cyc + 1;
      if (d0) begin req0 = 1'b1; we0 = w0; adr0 = a0; wd0 = v0; end
      if (d1 && off1 == 0) begin req1 = 1'b1; we1 = w1; adr1 = a1; wd1 = v1; end
      for (int k = 0; k < 2; k++) begin
         tg[k] = -1; tv[k] = -1; ng[k] = 0; nv[k] = 0; got_data[k] = 32'd0;
      end
      nwe = 0; excl_bad = 0; we_bad = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         rel = cyc - p;
         if (gnt0 && gnt1) excl_bad++;
         if (rvalid0 && rvalid1) excl_bad++;
         if (mem_we && !(gnt0 || gnt1)) we_bad++;
         if (mem_we) nwe++;
         if (gnt0) begin
            ng[0]++; tg[0] = rel;
            req0 = 1'b0; we0 = 1'($urandom); adr0 = $urandom; wd0 = $urandom;
         end
         if (gnt1) begin
            ng[1]++; tg[1] = rel;
            req1 = 1'b0; we1 = 1'($urandom); adr1 = $urandom; wd1 = $urandom;
         end
         if (rvalid0) begin nv[0]++; tv[0] = rel; got_data[0] = rd0; end
         if (rvalid1) begin nv[1]++; tv[1] = rel; got_data[1] = rd1; end
         if (d1 && off1 > 0 && k == off1) begin
            req1 = 1'b1; we1 = w1; adr1 = a1; wd1 = v1;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;

      for (int k = 0; k < 2; k++) begin
         string pn;
         pn = (k == 0) ? "_p0" : "_p1";
         if (dd[k]) begin
            check({tag, pn, "_ngnt"}, ng[k], 1);
            check({tag, pn, "_tgnt"}, tg[k], exp_g[k]);
            if (ww[k]) begin
               check({tag, pn, "_nrvalid"}, nv[k], 0);
            end else begin
               check({tag, pn, "_nrvalid"}, nv[k], 1);
               check({tag, pn, "_trvalid"}, tv[k], exp_g[k] + 2);
               check({tag, pn, "_rdata"}, got_data[k], exp_data[k]);
            end
         end else begin
            check({tag, pn, "_ngnt"}, ng[k], 0);
            check({tag, pn, "_nrvalid"}, nv[k], 0);
         end
      end
      check({tag, "_nwe"}, nwe, exp_nwe);
      check({tag, "_excl"}, excl_bad, 0);
      check({tag, "_we_outside_issue"}, we_bad, 0);
      check({tag, "_rd0_hold"}, rd0, exp_rd[0]);
      check({tag, "_rd1_hold"}, rd1, exp_rd[1]);
      $display("txn %s: p0(%0d w%0d a=%h) p1(%0d w%0d a=%h off=%0d) first=p%0d", tag,
               d0, w0, a0, d1, w1, a1, off1, first);
   endtask

   initial begin
      int p;
      rstb = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;
      mem_rd = '0;
      for (int i = 0; i < 64; i++) begin
         ref_mem[i]  = $urandom;
         phys_mem[i] = ref_mem[i];
      end
      ref_mem[4]  = 32'hDEADBEEF;
      phys_mem[4] = 32'hDEADBEEF;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      m_last_owner = 1;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rstb = 1'b0;
      $display("reset released");

      run_pair("single_read_p0", 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      run_pair("single_write_p1", 0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678, 0);
      run_pair("readback_p0", 1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      run_pair("tie_a", 1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0, 0);
      run_pair("tie_b", 1, 0, 32'h38, 32'h0, 1, 0, 32'h3C, 32'h0, 0);
      run_pair("busy_issue", 1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0, 1);
      run_pair("busy_data", 1, 0, 32'h48, 32'h0, 1, 1, 32'h4C, 32'hA5A5_0001, 2);
      run_pair("busy_after_write", 1, 1, 32'h50, 32'hC0DE_0002, 1, 0, 32'h50, 32'h0, 2);

      // Reset while a port-0 read sits in DATA.
      @(negedge clk);
      p = cyc + 1;
      req0 = 1'b1; we0 = 1'b0; adr0 = 32'h10;
      @(negedge clk);
      check("rst_mid_gnt0", {31'd0, gnt0}, 32'd1);
      req0 = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      check_all_zero("rst_mid");
      rstb = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      m_last_owner = 1;
      @(negedge clk);
      check("rst_mid_no_rvalid0", {31'd0, rvalid0}, 32'd0);
      $display("reset during DATA at cycle %0d", p + 1);
      run_pair("post_reset_tie", 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0);

      for (int i = 0; i < 40; i++) begin
         bit d0r, d1r;
         int offr;
         d0r = 1'($urandom);
         d1r = 1'($urandom);
         if (!d0r && !d1r) d0r = 1'b1;
         offr = (d0r && d1r) ? int'($urandom_range(0, 2)) : 0;
         run_pair($sformatf("rand%0d", i),
                  d0r, 1'($urandom), {24'd0, 6'($urandom), 2'b00}, $urandom,
                  d1r, 1'($urandom), {24'd0, 6'($urandom), 2'b00}, $urandom, offr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
